// File: rtl/store_trace_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_trace_pkg
// Description : Shared types for the store trace checker: memwrite/size
//               encoding, failure codes, checker states and the helper that
//               turns an access size into a data compare mask.
// Revision    : 1.0 - initial release
// ============================================================================
package store_trace_pkg;

  // Store size encoding, shared by memwrite and exp_size.
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  // Widest data path the mask helper supports.
  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_ADDR     = 3'd1,
    FC_DATA     = 3'd2,
    FC_SIZE     = 3'd3,
    FC_TIMEOUT  = 3'd4,
    FC_OVERFLOW = 3'd5,
    FC_ILLEGAL  = 3'd6
  } fail_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  // Bits of the data bus that take part in a compare for a given size.
  // Sub-word data is right-aligned, so only the low lanes are kept.
  function automatic logic [MAX_DATA_W-1:0] size_mask(input logic [1:0] size);
    logic [MAX_DATA_W-1:0] m;
    case (size)
      SZ_BYTE: m = {{(MAX_DATA_W-8){1'b0}}, 8'hFF};
      SZ_HALF: m = {{(MAX_DATA_W-16){1'b0}}, 16'hFFFF};
      SZ_WORD: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_trace_checker_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO holding the expected-store entries.
//               Supports push and pop on the same edge, including when full
//               (the pop frees the slot the push uses).
// Ports       : clk_i, reset_i (async, active-high), flush_i (sync empty),
//               push_i/wdata_i, pop_i/rdata_o (head, valid when !empty_o),
//               full_o, empty_o, count_o.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 66
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/store_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : store_trace_checker
// Description : Checks the core's data-memory write port against an ordered
//               list of expected stores. Stores inside the address window are
//               compared with the FIFO head (addr > size > data priority);
//               a watchdog fails the run if no match arrives in time.
// Ports       : clk, reset (async, active-high); memwrite/dataadr/writedata
//               (observed store); exp_wr/exp_addr/exp_data/exp_size, exp_full
//               (expected-store load); start, clear (control); done, pass,
//               fail, fail_code, match_cnt (registered results).
// Revision    : 1.0 - initial release
// ============================================================================
module store_trace_checker
  import store_trace_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 8,
  parameter int              TIMEOUT  = 1000,
  parameter logic [ADDR_W-1:0] WIN_BASE = '0,
  parameter logic [ADDR_W-1:0] WIN_MASK = '0,
  parameter int              STRICT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             memwrite,
  input  logic [ADDR_W-1:0]      dataadr,
  input  logic [DATA_W-1:0]      writedata,
  input  logic                   exp_wr,
  input  logic [ADDR_W-1:0]      exp_addr,
  input  logic [DATA_W-1:0]      exp_data,
  input  logic [1:0]             exp_size,
  output logic                   exp_full,
  input  logic                   start,
  input  logic                   clear,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [2:0]             fail_code,
  output logic [$clog2(DEPTH):0] match_cnt
);

  localparam int ENTRY_W = ADDR_W + DATA_W + 2;
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q;
  fail_code_e         fail_code_q;
  logic               pass_q, fail_q, done_q;
  logic [CNT_W-1:0]   match_cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic               ovf_q;      // overflow seen while loading in IDLE
  logic               illegal_q;  // size-00 entry loaded in IDLE

  logic [ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_data;
  logic [1:0]         w_head_size;
  logic [DATA_W-1:0]  w_mask;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_fifo_full, w_fifo_empty;
  logic               w_loading, w_watched, w_cmp_valid;
  logic               w_addr_ok, w_size_ok, w_data_ok;
  logic               w_match, w_mismatch, w_push, w_ovf, w_illegal_push;
  logic               w_empties, w_timeout;
  fail_code_e         w_mis_code;

  assign {w_head_addr, w_head_data, w_head_size} = w_head;
  assign w_mask = DATA_W'(size_mask(w_head_size));

  assign w_loading   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign w_watched   = (memwrite != SZ_NONE) &&
                       (((dataadr ^ WIN_BASE) & ~WIN_MASK) == '0);
  assign w_cmp_valid = (state_q == ST_RUN) && w_watched && !w_fifo_empty;
  assign w_addr_ok   = (dataadr == w_head_addr);
  assign w_size_ok   = (memwrite == w_head_size);
  assign w_data_ok   = (((writedata ^ w_head_data) & w_mask) == '0);
  assign w_match     = w_cmp_valid && w_addr_ok && w_size_ok && w_data_ok;
  assign w_mismatch  = w_cmp_valid && !w_match && (STRICT != 0);

  // A full FIFO still accepts a push when the head pops on the same edge.
  assign w_push         = exp_wr && w_loading && (!w_fifo_full || w_match);
  assign w_ovf          = exp_wr && w_loading && w_fifo_full && !w_match;
  assign w_illegal_push = w_push && (exp_size == SZ_NONE);
  // Last entry consumed with nothing arriving behind it.
  assign w_empties      = w_match && (w_fifo_count == CNT_W'(1)) && !w_push;
  assign w_timeout      = (timer_q == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    w_mis_code = FC_DATA;
    if (!w_addr_ok)      w_mis_code = FC_ADDR;
    else if (!w_size_ok) w_mis_code = FC_SIZE;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (clear),
    .push_i  (w_push),
    .wdata_i ({exp_addr, exp_data, exp_size}),
    .pop_i   (w_match),
    .rdata_o (w_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      state_q     <= ST_IDLE;
      fail_code_q <= FC_NONE;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      match_cnt_q <= '0;
      timer_q     <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_ovf)          ovf_q     <= 1'b1;
          if (w_illegal_push) illegal_q <= 1'b1;
          if (start) begin
            timer_q <= '0;
            if (ovf_q || w_ovf) begin
              state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
              fail_code_q <= FC_OVERFLOW;
            end else if (illegal_q || w_illegal_push) begin
              state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
              fail_code_q <= FC_ILLEGAL;
            end else if (w_fifo_empty && !w_push) begin
              state_q <= ST_PASS; pass_q <= 1'b1; done_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (w_mismatch) begin
            state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
            fail_code_q <= w_mis_code;
          end else if (w_ovf) begin
            state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
            fail_code_q <= FC_OVERFLOW;
          end else if (w_illegal_push) begin
            state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
            fail_code_q <= FC_ILLEGAL;
          end else if (w_match) begin
            match_cnt_q <= match_cnt_q + 1'b1;
            timer_q     <= '0;
            if (w_empties) begin
              state_q <= ST_PASS; pass_q <= 1'b1; done_q <= 1'b1;
            end
          end else if (w_timeout) begin
            state_q <= ST_FAIL; fail_q <= 1'b1; done_q <= 1'b1;
            fail_code_q <= FC_TIMEOUT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: ; // PASS and FAIL hold until reset or clear
      endcase
    end
  end

  assign exp_full  = w_fifo_full;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_store_trace_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_trace_checker
// Description : Self-checking bench for store_trace_checker. Three instances
//               share one stimulus bus: a strict watch-everything checker, a
//               strict checker with a 16-byte window at 0x50, and a lenient
//               watch-everything checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_trace_checker;

  localparam logic [1:0] W = 2'b01, H = 2'b10, B = 2'b11, N = 2'b00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memwrite = '0;
  logic [31:0] dataadr = '0, writedata = '0;
  logic        exp_wr = 1'b0;
  logic [31:0] exp_addr = '0, exp_data = '0;
  logic [1:0]  exp_size = '0;
  logic        start = 1'b0, clear = 1'b0;

  logic       d_full, d_done, d_pass, d_fail;
  logic [2:0] d_code;
  logic [3:0] d_cnt;
  logic       w_full, w_done, w_pass, w_fail;
  logic [2:0] w_code;
  logic [3:0] w_cnt;
  logic       l_full, l_done, l_pass, l_fail;
  logic [2:0] l_code;
  logic [3:0] l_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_trace_checker #(.DEPTH(8), .TIMEOUT(20), .WIN_BASE(32'h0),
                        .WIN_MASK(32'hFFFF_FFFF), .STRICT(1)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_wr(exp_wr), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_size(exp_size), .exp_full(d_full),
    .start(start), .clear(clear), .done(d_done), .pass(d_pass),
    .fail(d_fail), .fail_code(d_code), .match_cnt(d_cnt));

  store_trace_checker #(.DEPTH(8), .TIMEOUT(20), .WIN_BASE(32'h50),
                        .WIN_MASK(32'h0000_000F), .STRICT(1)) dut_win (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_wr(exp_wr), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_size(exp_size), .exp_full(w_full),
    .start(start), .clear(clear), .done(w_done), .pass(w_pass),
    .fail(w_fail), .fail_code(w_code), .match_cnt(w_cnt));

  store_trace_checker #(.DEPTH(8), .TIMEOUT(20), .WIN_BASE(32'h0),
                        .WIN_MASK(32'hFFFF_FFFF), .STRICT(0)) dut_len (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .exp_wr(exp_wr), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_size(exp_size), .exp_full(l_full),
    .start(start), .clear(clear), .done(l_done), .pass(l_pass),
    .fail(l_fail), .fail_code(l_code), .match_cnt(l_cnt));

  typedef struct {
    int          ne;
    logic [31:0] ea0, ed0, ea1, ed1;
    logic [1:0]  es0, es1;
    int          ns;
    logic [31:0] sa0, sd0, sa1, sd1;
    logic [1:0]  ss0, ss1;
    logic        e_pass, e_fail;
    logic [2:0]  e_code;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(int ne,
      logic [31:0] ea0, logic [31:0] ed0, logic [1:0] es0,
      logic [31:0] ea1, logic [31:0] ed1, logic [1:0] es1, int ns,
      logic [31:0] sa0, logic [31:0] sd0, logic [1:0] ss0,
      logic [31:0] sa1, logic [31:0] sd1, logic [1:0] ss1,
      logic ep, logic ef, logic [2:0] ec, logic [3:0] cn);
    vec_t v;
    v.ne = ne; v.ea0 = ea0; v.ed0 = ed0; v.es0 = es0;
    v.ea1 = ea1; v.ed1 = ed1; v.es1 = es1; v.ns = ns;
    v.sa0 = sa0; v.sd0 = sd0; v.ss0 = ss0;
    v.sa1 = sa1; v.sd1 = sd1; v.ss1 = ss1;
    v.e_pass = ep; v.e_fail = ef; v.e_code = ec; v.e_cnt = cn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    exp_wr = 1'b1; exp_addr = a; exp_data = d; exp_size = s;
    tick();
    exp_wr = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    memwrite = s; dataadr = a; writedata = d;
    tick();
    memwrite = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Waits for the strict checker to finish; an expired bound is a failure.
  task automatic wait_done(input string name);
    int k = 0;
    while (!d_done && k < 40) begin tick(); k++; end
    check({name, "_done_in_time"}, 32'(d_done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    // ne, exp0, exp1, ns, store0, store1, pass, fail, code, cnt
    vecs.push_back(mk(1, 32'd80, 32'hFF, B, 0, 0, N,
                      1, 32'd80, 32'hABCD12FF, B, 0, 0, N, 1, 0, 3'd0, 4'd1));
    vecs.push_back(mk(2, 32'd84, 32'h1234, H, 32'd88, 32'hDEADBEEF, W,
                      2, 32'd84, 32'hFFFF1234, H, 32'd88, 32'hDEADBEEF, W,
                      1, 0, 3'd0, 4'd2));
    vecs.push_back(mk(2, 32'd84, 32'h1234, H, 32'd88, 32'hDEADBEEF, W,
                      2, 32'd88, 32'hDEADBEEF, W, 32'd84, 32'h1234, H,
                      0, 1, 3'd1, 4'd0));
    vecs.push_back(mk(1, 32'd80, 32'hFF, B, 0, 0, N,
                      1, 32'd80, 32'hFF, W, 0, 0, N, 0, 1, 3'd3, 4'd0));
    vecs.push_back(mk(1, 32'd80, 32'hFF, B, 0, 0, N,
                      1, 32'd80, 32'hFE, B, 0, 0, N, 0, 1, 3'd2, 4'd0));
    vecs.push_back(mk(1, 32'd80, 32'hFF, B, 0, 0, N,
                      1, 32'd84, 32'h0, W, 0, 0, N, 0, 1, 3'd1, 4'd0));
    vecs.push_back(mk(2, 32'd84, 32'h1234, H, 32'd88, 32'hDEADBEEF, W,
                      2, 32'd84, 32'hAAAA1234, H, 32'd88, 32'hDEADBEEE, W,
                      0, 1, 3'd2, 4'd1));
    vecs.push_back(mk(0, 0, 0, N, 0, 0, N, 0, 0, 0, N, 0, 0, N,
                      1, 0, 3'd0, 4'd0));
    vecs.push_back(mk(1, 32'd80, 32'hFF, N, 0, 0, N,
                      0, 0, 0, N, 0, 0, N, 0, 1, 3'd6, 4'd0));

    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 32'(d_done), 32'd0);
    check("reset_pass", 32'(d_pass), 32'd0);
    check("reset_fail", 32'(d_fail), 32'd0);
    check("reset_code", 32'(d_code), 32'd0);
    check("reset_cnt",  32'(d_cnt),  32'd0);
    check("reset_full", 32'(d_full), 32'd0);
    reset = 1'b0;
    tick();

    // ---- table-driven single/double store scenarios ----
    for (int v = 0; v < vecs.size(); v++) begin
      do_clear();
      if (vecs[v].ne > 0) push_exp(vecs[v].ea0, vecs[v].ed0, vecs[v].es0);
      if (vecs[v].ne > 1) push_exp(vecs[v].ea1, vecs[v].ed1, vecs[v].es1);
      sb.push_back(vecs[v]);
      do_start();
      if (vecs[v].ns > 0) store(vecs[v].sa0, vecs[v].sd0, vecs[v].ss0);
      if (vecs[v].ns > 1) store(vecs[v].sa1, vecs[v].sd1, vecs[v].ss1);
      wait_done($sformatf("vec%0d", v));
      e = sb.pop_front();
      check($sformatf("vec%0d_pass", v), 32'(d_pass), 32'(e.e_pass));
      check($sformatf("vec%0d_fail", v), 32'(d_fail), 32'(e.e_fail));
      check($sformatf("vec%0d_code", v), 32'(d_code), 32'(e.e_code));
      check($sformatf("vec%0d_cnt", v),  32'(d_cnt),  32'(e.e_cnt));
    end

    // ---- one-edge latency, and start ignored once PASS is reached ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    do_start();
    check("lat_done_before", 32'(d_done), 32'd0);
    store(32'd80, 32'hABCD12FF, B);
    check("lat_pass", 32'(d_pass), 32'd1);
    check("lat_done", 32'(d_done), 32'd1);
    check("lat_cnt",  32'(d_cnt),  32'd1);
    do_start();
    check("pass_sticky_after_start", 32'(d_pass), 32'd1);

    // ---- address window: store outside window ignored ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    do_start();
    store(32'h100, 32'h11, B);
    check("win_ignored_done", 32'(w_done), 32'd0);
    check("win_alldut_code",  32'(d_code), 32'd1);
    store(32'd80, 32'hFF, B);
    check("win_pass", 32'(w_pass), 32'd1);
    check("win_cnt",  32'(w_cnt),  32'd1);

    // ---- lenient checker skips mismatching stores ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    do_start();
    store(32'd80, 32'hFE, B);
    store(32'd84, 32'hFF, B);
    check("len_no_fail", 32'(l_done), 32'd0);
    store(32'd80, 32'h12FF, B);
    check("len_pass", 32'(l_pass), 32'd1);
    check("len_cnt",  32'(l_cnt),  32'd1);

    // ---- watchdog: fail exactly TIMEOUT edges after start ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    do_start();
    repeat (19) tick();
    check("tmo_not_yet", 32'(d_fail), 32'd0);
    tick();
    check("tmo_fail", 32'(d_fail), 32'd1);
    check("tmo_code", 32'(d_code), 32'd4);

    // ---- async reset in the middle of RUN ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    push_exp(32'd84, 32'hFF, B);
    do_start();
    store(32'd80, 32'hFF, B);
    check("rst_pre_cnt", 32'(d_cnt), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_cnt",  32'(d_cnt),  32'd0);
    check("rst_async_done", 32'(d_done), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    tick();

    // ---- overflow while loading in IDLE, then clear ----
    do_clear();
    for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(4 * i), 32'(i), W);
    check("ovf_full", 32'(d_full), 32'd1);
    push_exp(32'h200, 32'h9, W);
    do_start();
    check("ovf_fail", 32'(d_fail), 32'd1);
    check("ovf_code", 32'(d_code), 32'd5);
    do_clear();
    check("ovf_clear_full", 32'(d_full), 32'd0);
    check("ovf_clear_done", 32'(d_done), 32'd0);

    // ---- push into a full FIFO on the edge the head pops ----
    for (int i = 0; i < 8; i++) push_exp(32'h100 + 32'(4 * i), 32'(i), W);
    do_start();
    exp_wr = 1'b1; exp_addr = 32'h120; exp_data = 32'h8; exp_size = W;
    store(32'h100, 32'h0, W);
    exp_wr = 1'b0;
    check("pp_no_ovf", 32'(d_fail), 32'd0);
    check("pp_full",   32'(d_full), 32'd1);
    for (int i = 1; i < 9; i++) store(32'h100 + 32'(4 * i), 32'(i), W);
    check("pp_pass", 32'(d_pass), 32'd1);
    check("pp_cnt",  32'(d_cnt),  32'd9);

    // ---- push on the edge the FIFO would empty: no early PASS ----
    do_clear();
    push_exp(32'd80, 32'hFF, B);
    do_start();
    exp_wr = 1'b1; exp_addr = 32'd84; exp_data = 32'hBEEF; exp_size = H;
    store(32'd80, 32'hFF, B);
    exp_wr = 1'b0;
    check("late_push_no_pass", 32'(d_done), 32'd0);
    check("late_push_cnt",     32'(d_cnt),  32'd1);
    store(32'd84, 32'h0000BEEF, H);
    check("late_push_pass", 32'(d_pass), 32'd1);
    check("late_push_cnt2", 32'(d_cnt),  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_trace_checker.md
Name: store_trace_checker

Overview:
- Synthesisable, parametrised store checker for the pipelined MIPS core's data-memory write port. Generalises the single-store pass/fail check to an ordered sequence of DEPTH expected stores, each with its own access size.
- Adds address-window filtering, a watchdog timeout and failure diagnostics.
- Sits beside top, sampling dataadr/writedata/memwrite; usable from benches and on FPGA (pass/fail to LEDs).

Parameters:
- DATA_W, 32, width of writedata / expected data.
- ADDR_W, 32, width of dataadr / expected address.
- DEPTH, 8, expected-store FIFO entries; power of two, >= 2.
- TIMEOUT, 1000, max cycles in RUN between consecutive matches (or from start) before failure; >= 1.
- WIN_BASE, 0, base of watched address window.
- WIN_MASK, 0, address bits ignored for window test; 0 watches only WIN_BASE exactly.
- STRICT, 1, 1: every watched store must match head; 0: non-matching watched stores are skipped silently.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- memwrite  in  2  store qualifier/size: 00 none, 01 word, 10 half, 11 byte.
- dataadr  in  ADDR_W  store address.
- writedata  in  DATA_W  store data, sub-word data right-aligned.
- exp_wr  in  1  push expected entry.
- exp_addr  in  ADDR_W  expected address.
- exp_data  in  DATA_W  expected data.
- exp_size  in  2  expected size, same encoding as memwrite (00 illegal).
- exp_full  out  1  FIFO full.
- start  in  1  pulse: begin checking.
- clear  in  1  synchronous return to IDLE, FIFO flushed.
- done  out  1  PASS or FAIL reached.
- pass  out  1  all expected stores matched.
- fail  out  1  check failed.
- fail_code  out  3  0 none, 1 addr mismatch, 2 data mismatch, 3 size mismatch, 4 timeout, 5 overflow, 6 illegal size.
- match_cnt  out  $clog2(DEPTH)+1  stores matched so far.

Behaviour:
- Reset (async): state IDLE, FIFO empty, all outputs 0, timer 0.
- States IDLE, RUN, PASS, FAIL; PASS/FAIL sticky until reset or clear.
- exp_wr accepted in IDLE and RUN when not full. Push when full: entry dropped; in RUN go FAIL code 5, in IDLE latch overflow so next start goes FAIL code 5. exp_size 00 pushed -> FAIL code 6 on start/at push in RUN.
- IDLE + start: FIFO empty -> PASS next edge; else RUN, timer 0.
- RUN, each edge: watched store = memwrite != 0 and ((dataadr ^ WIN_BASE) & ~WIN_MASK) == 0. Unwatched stores ignored.
- Watched store compare vs head, priority addr > size > data; data compared on low 8/16/32 bits per size, upper bits don't-care.
- Full match: pop, match_cnt+1, timer 0; if FIFO becomes empty -> PASS same edge.
- Mismatch: STRICT=1 -> FAIL with code; STRICT=0 -> ignored, head kept.
- No match in a cycle: timer+1; timer reaching TIMEOUT-1 with no match -> FAIL code 4.
- Simultaneous push and pop in RUN when full: allowed, no overflow (pop first).
- Push on same edge FIFO would empty: no PASS; check continues.
- start in RUN/PASS/FAIL ignored; clear has priority over all in-cycle events.
- done = pass | fail, registered; outputs change one edge after the causing sample (latency 1).

Decomposition:
- Package store_trace_pkg: size encoding constants (SZ_NONE/WORD/HALF/BYTE), fail_code enum, state enum, size-to-mask function.
- Sub-module sync_fifo (DEPTH, width ADDR_W+DATA_W+2), with full/empty and simultaneous push/pop; checker FSM and comparator in top-level.

Test Plan:
- Push {80, 0x000000FF, byte}, start, store byte 80 data 0xABCD12FF -> pass=1, match_cnt=1, fail_code=0 one edge later.
- Push {84, 0x1234, half},{88, 0xDEADBEEF, word}; stores in order -> pass after second; swapped order -> fail, code 1, match_cnt=0.
- STRICT=1, expect {80, 0xFF, byte}, store word 80 -> fail code 3; store byte 80 data 0xFE -> fail code 2.
- WIN_BASE=80, WIN_MASK=0xF: store to 0x100 ignored, then matching store to 80 -> pass.
- TIMEOUT=20, one entry, no stores after start -> fail code 4 at 20th edge; reset mid-RUN -> all outputs 0 immediately.
- Push DEPTH+1 entries in IDLE, start -> fail code 5; clear -> IDLE, exp_full=0, done=0.
